// File: rtl/float_copro_bridge.sv
// float_copro_bridge: sequences queued FP requests into the coprocessor
// valid/complete handshake and returns results through a one-entry register.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cpu_valid/cpu_ready         request handshake (ready = FIFO not full)
//   cpu_opcode, cpu_op0/op1     request payload
//   res_valid/res_ready         result handshake
//   res_data, res_err           result word, timeout-abort flag
//   copro_valid                 held high from dispatch until completion
//   copro_opcode, copro_op0/1   operation presented to the coprocessor
//   copro_complete, copro_result  completion level and result
//   ops_done                    results loaded so far (wraps)
module float_copro_bridge #(
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_valid,
   output logic        cpu_ready,
   input  logic [10:0] cpu_opcode,
   input  logic [31:0] cpu_op0,
   input  logic [31:0] cpu_op1,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_err,
   output logic        copro_valid,
   output logic [10:0] copro_opcode,
   output logic [31:0] copro_op0,
   output logic [31:0] copro_op1,
   input  logic        copro_complete,
   input  logic [31:0] copro_result,
   output logic [15:0] ops_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DROP
   } state_e;

   typedef struct packed {
      logic [10:0] opcode;
      logic [31:0] op0;
      logic [31:0] op1;
   } req_t;

   req_t        mem_q [DEPTH];
   req_t        mem_d [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   state_e      state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic        cv_q, cv_d;
   logic [10:0] copc_q, copc_d;
   logic [31:0] cop0_q, cop0_d;
   logic [31:0] cop1_q, cop1_d;
   logic        rv_q, rv_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rerr_q, rerr_d;
   logic [15:0] ops_done_q, ops_done_d;

   logic full, empty, push;
   req_t head;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // Held low through reset so nothing is accepted until the FIFO is clean.
   assign cpu_ready = rst_n && !full;
   assign push      = cpu_valid && cpu_ready;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      state_d    = state_q;
      tmr_d      = tmr_q;
      cv_d       = cv_q;
      copc_d     = copc_q;
      cop0_d     = cop0_q;
      cop1_d     = cop1_q;
      rv_d       = rv_q;
      rdata_d    = rdata_q;
      rerr_d     = rerr_q;
      ops_done_d = ops_done_q;

      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = '{cpu_opcode, cpu_op0, cpu_op1};
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (rv_q && res_ready) begin
         rv_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            // Dispatch only into an empty result register so a load
            // and a take can never land on the same edge.
            if (!empty && !rv_q) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               copc_d   = head.opcode;
               cop0_d   = head.op0;
               cop1_d   = head.op1;
               cv_d     = 1'b1;
               tmr_d    = '0;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            tmr_d = tmr_q + 1'b1;
            if (copro_complete) begin
               rdata_d    = copro_result;
               rerr_d     = 1'b0;
               rv_d       = 1'b1;
               ops_done_d = ops_done_q + 16'd1;
               cv_d       = 1'b0;
               state_d    = S_DROP;
            end else if (tmr_q == TMAX) begin
               rdata_d    = QNAN;
               rerr_d     = 1'b1;
               rv_d       = 1'b1;
               ops_done_d = ops_done_q + 16'd1;
               cv_d       = 1'b0;
               state_d    = S_DROP;
            end
         end
         S_DROP: begin
            // One low cycle lets the coprocessor re-arm.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         cv_q       <= 1'b0;
         copc_q     <= '0;
         cop0_q     <= '0;
         cop1_q     <= '0;
         rv_q       <= 1'b0;
         rdata_q    <= '0;
         rerr_q     <= 1'b0;
         ops_done_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         cv_q       <= cv_d;
         copc_q     <= copc_d;
         cop0_q     <= cop0_d;
         cop1_q     <= cop1_d;
         rv_q       <= rv_d;
         rdata_q    <= rdata_d;
         rerr_q     <= rerr_d;
         ops_done_q <= ops_done_d;
      end
   end

   // Storage needs no reset: pointers define which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign res_valid    = rv_q;
   assign res_data     = rdata_q;
   assign res_err      = rerr_q;
   assign copro_valid  = cv_q;
   assign copro_opcode = copc_q;
   assign copro_op0    = cop0_q;
   assign copro_op1    = cop1_q;
   assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_float_copro_bridge.sv
// tb_float_copro_bridge: self-checking bench with a behavioural coprocessor
// stub, result/dispatch scoreboards and a short-timeout second instance.
module tb_float_copro_bridge;

   typedef struct {
      logic [10:0] opc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance 0: default parameters, stub coprocessor
   logic        p0_valid = 1'b0, p0_rdy;
   logic [10:0] p0_opc = '0;
   logic [31:0] p0_a = '0, p0_b = '0;
   logic        p0_rv, r0_ready = 1'b1, p0_err, p0_cv;
   logic [31:0] p0_rdata, p0_cop0, p0_cop1, p0_cres;
   logic [10:0] p0_copc;
   logic        p0_cpl;
   logic [15:0] p0_ops;

   // instance 1: TIMEOUT = 16, completion driven by hand
   logic        p1_valid = 1'b0, p1_rdy;
   logic [10:0] p1_opc = '0;
   logic [31:0] p1_a = '0, p1_b = '0;
   logic        p1_rv, r1_ready = 1'b1, p1_err, p1_cv;
   logic [31:0] p1_rdata, p1_cop0, p1_cop1;
   logic [10:0] p1_copc;
   logic        c1_cpl = 1'b0;
   logic [31:0] c1_res = '0;
   logic [15:0] p1_ops;

   float_copro_bridge u0 (
      .clk(clk), .rst_n(rst_n),
      .cpu_valid(p0_valid), .cpu_ready(p0_rdy),
      .cpu_opcode(p0_opc), .cpu_op0(p0_a), .cpu_op1(p0_b),
      .res_valid(p0_rv), .res_ready(r0_ready),
      .res_data(p0_rdata), .res_err(p0_err),
      .copro_valid(p0_cv), .copro_opcode(p0_copc),
      .copro_op0(p0_cop0), .copro_op1(p0_cop1),
      .copro_complete(p0_cpl), .copro_result(p0_cres),
      .ops_done(p0_ops)
   );

   float_copro_bridge #(.DEPTH(2), .TIMEOUT(16)) u1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_valid(p1_valid), .cpu_ready(p1_rdy),
      .cpu_opcode(p1_opc), .cpu_op0(p1_a), .cpu_op1(p1_b),
      .res_valid(p1_rv), .res_ready(r1_ready),
      .res_data(p1_rdata), .res_err(p1_err),
      .copro_valid(p1_cv), .copro_opcode(p1_copc),
      .copro_op0(p1_cop0), .copro_op1(p1_cop1),
      .copro_complete(c1_cpl), .copro_result(c1_res),
      .ops_done(p1_ops)
   );

   int n_chk = 0;
   int n_pass = 0;
   int n_push = 0;
   int n_res = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic bound_fail(string nm);
      n_chk++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // ---- float helpers for the stub (exact normal values only) ----
   function automatic real s2r(logic [31:0] v);
      logic [63:0] d;
      if (v[30:0] == 31'd0) d = {v[31], 63'd0};
      else d = {v[31], 11'(v[30:23]) + 11'd896, v[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2s(real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   function automatic logic [31:0] fpu(logic [10:0] o, logic [31:0] a,
                                       logic [31:0] b);
      real x, y, r;
      x = s2r(a);
      y = s2r(b);
      case (o[1:0])
         2'd0: r = x + y;
         2'd1: r = x - y;
         2'd2: r = x * y;
         default: r = x / y;
      endcase
      return r2s(r);
   endfunction

   function automatic int lat(logic [10:0] o);
      case (o[1:0])
         2'd3: return 42;
         2'd2: return 6;
         default: return 7;
      endcase
   endfunction

   // ---- coprocessor stub for u0 ----
   int   s_cnt = 0;
   logic s_cpl = 1'b0;
   logic inj = 1'b0;
   logic [31:0] s_res = '0;

   always @(posedge clk) begin
      if (!p0_cv) begin
         s_cnt <= 0;
         s_cpl <= 1'b0;
      end else if (!s_cpl) begin
         s_cnt <= s_cnt + 1;
         if (s_cnt + 1 == lat(p0_copc)) begin
            s_cpl <= 1'b1;
            s_res <= fpu(p0_copc, p0_cop0, p0_cop1);
         end
      end
   end

   assign p0_cpl  = s_cpl | inj;
   assign p0_cres = s_res;

   // ---- scoreboards and monitors for u0 ----
   vec_t sq[$];
   vec_t dq[$];
   int   run_len = 0;
   int   last_len = 0;
   logic cv_prev = 1'b0;
   logic cv_at_res = 1'b0;

   always @(negedge clk) begin
      vec_t e;
      if (p0_cv) run_len++;
      else if (run_len != 0) begin
         last_len = run_len;
         run_len = 0;
      end
      if (p0_cv && !cv_prev) begin
         if (dq.size() == 0) begin
            n_chk++;
            $display("FAIL disp_unexpected: got %h want none", p0_cop0);
         end else begin
            e = dq.pop_front();
            chk("disp_opcode", 32'(p0_copc), 32'(e.opc));
            chk("disp_op0", p0_cop0, e.a);
            chk("disp_op1", p0_cop1, e.b);
         end
      end
      cv_prev = p0_cv;
      if (p0_rv && r0_ready) begin
         cv_at_res = p0_cv;
         if (sq.size() == 0) begin
            n_chk++;
            $display("FAIL res_unexpected: got %h want none", p0_rdata);
         end else begin
            e = sq.pop_front();
            chk("res_data", p0_rdata, e.exp);
            chk("res_err", 32'(p0_err), 32'd0);
         end
         n_res++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(vec_t v);
      sq.push_back(v);
      dq.push_back(v);
      n_push++;
   endtask

   task automatic push(vec_t v);
      int t;
      t = 0;
      while (!p0_rdy && t < 200) begin
         tick();
         t++;
      end
      if (!p0_rdy) bound_fail("push_ready");
      p0_valid = 1'b1;
      p0_opc = v.opc;
      p0_a = v.a;
      p0_b = v.b;
      sb_push(v);
      tick();
      p0_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (n_res != n_push && t < 500) begin
         tick();
         t++;
      end
      if (n_res != n_push) bound_fail("drain");
   endtask

   vec_t tbl[8];

   initial begin
      int t;
      logic seen;

      tbl[0] = '{11'h000, 32'h3FC00000, 32'h40100000, 32'h40700000};
      tbl[1] = '{11'h001, 32'h40400000, 32'h3F800000, 32'h40000000};
      tbl[2] = '{11'h002, 32'h40000000, 32'h40400000, 32'h40C00000};
      tbl[3] = '{11'h003, 32'h40C00000, 32'h40000000, 32'h40400000};
      tbl[4] = '{11'h7FC, 32'h3F800000, 32'hC0400000, 32'hC0000000};
      tbl[5] = '{11'h405, 32'h40000000, 32'h40400000, 32'hBF800000};
      tbl[6] = '{11'h002, 32'hC0000000, 32'h3F000000, 32'hBF800000};
      tbl[7] = '{11'h003, 32'h3F800000, 32'h40800000, 32'h3E800000};

      // reset state
      tick();
      tick();
      chk("rst_cpu_ready", 32'(p0_rdy), 32'd0);
      chk("rst_res_valid", 32'(p0_rv), 32'd0);
      chk("rst_copro_valid", 32'(p0_cv), 32'd0);
      chk("rst_ops_done", 32'(p0_ops), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(p0_rdy), 32'd1);

      // single add
      push(tbl[0]);
      drain();
      chk("add_valid_len", 32'(last_len), 32'd8);
      chk("add_drop_low", 32'(cv_at_res), 32'd0);
      chk("add_ops_done", 32'(p0_ops), 32'd1);

      // table sweep
      for (int i = 0; i < 8; i++) begin
         push(tbl[i]);
         drain();
         chk("tbl_ops_done", 32'(p0_ops), 32'(i + 2));
      end

      // back-to-back sub, mul, div
      tick();
      chk("b2b_ready0", 32'(p0_rdy), 32'd1);
      p0_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         p0_opc = tbl[i].opc;
         p0_a = tbl[i].a;
         p0_b = tbl[i].b;
         sb_push(tbl[i]);
         tick();
      end
      p0_valid = 1'b0;
      chk("b2b_full", 32'(p0_rdy), 32'd0);
      t = 0;
      while (!p0_rdy && t < 100) begin
         tick();
         t++;
      end
      if (!p0_rdy) bound_fail("b2b_recover");
      chk("b2b_recover_op", 32'(p0_copc), 32'(tbl[2].opc));
      chk("b2b_recover_op1", p0_cop1, tbl[2].b);
      drain();

      // backpressure
      r0_ready = 1'b0;
      push(tbl[4]);
      push(tbl[0]);
      t = 0;
      while (!p0_rv && t < 100) begin
         tick();
         t++;
      end
      if (!p0_rv) bound_fail("bp_first_result");
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (p0_cv) seen = 1'b1;
      end
      chk("bp_no_dispatch", 32'(seen), 32'd0);
      chk("bp_res_held", 32'(p0_rv), 32'd1);
      r0_ready = 1'b1;
      tick();
      chk("bp_take_edge", 32'(p0_cv), 32'd0);
      tick();
      chk("bp_dispatch", 32'(p0_cv), 32'd1);
      chk("bp_dispatch_op0", p0_cop0, tbl[0].a);
      drain();

      // reset during a div with one entry queued
      push(tbl[3]);
      push(tbl[0]);
      for (int i = 0; i < 5; i++) tick();
      chk("mid_in_wait", 32'(p0_cv), 32'd1);
      rst_n = 1'b0;
      tick();
      sq.delete();
      dq.delete();
      n_push = n_res;
      chk("mid_rst_ready", 32'(p0_rdy), 32'd0);
      chk("mid_rst_cv", 32'(p0_cv), 32'd0);
      chk("mid_rst_rv", 32'(p0_rv), 32'd0);
      chk("mid_rst_err", 32'(p0_err), 32'd0);
      chk("mid_rst_data", p0_rdata, 32'd0);
      chk("mid_rst_ops", 32'(p0_ops), 32'd0);
      chk("mid_rst_copc", 32'(p0_copc), 32'd0);
      chk("mid_rst_op0", p0_cop0, 32'd0);
      chk("mid_rst_op1", p0_cop1, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("mid_ready_back", 32'(p0_rdy), 32'd1);
      inj = 1'b1;
      tick();
      inj = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (p0_cv || p0_rv) seen = 1'b1;
      end
      chk("mid_fifo_empty", 32'(seen), 32'd0);
      chk("mid_stray_ops", 32'(p0_ops), 32'd0);
      push(tbl[0]);
      drain();
      chk("mid_fresh_ops", 32'(p0_ops), 32'd1);

      // ops_done wrap
      force u0.ops_done_q = 16'hFFFE;
      tick();
      release u0.ops_done_q;
      tick();
      push(tbl[5]);
      drain();
      chk("wrap_ffff", 32'(p0_ops), 32'h0000FFFF);
      push(tbl[6]);
      drain();
      chk("wrap_zero", 32'(p0_ops), 32'h00000000);

      // timeout on u1 followed by a normal op
      chk("to_ready", 32'(p1_rdy), 32'd1);
      p1_valid = 1'b1;
      p1_opc = 11'h000;
      p1_a = 32'h3F800000;
      p1_b = 32'h3F800000;
      tick();
      p1_opc = 11'h002;
      p1_a = 32'h40000000;
      p1_b = 32'h40400000;
      tick();
      p1_valid = 1'b0;
      t = 0;
      while (p1_cv && t < 100) begin
         t++;
         tick();
      end
      chk("to_wait_len", 32'(t), 32'd16);
      chk("to_res_valid", 32'(p1_rv), 32'd1);
      chk("to_res_data", p1_rdata, 32'h7FC00000);
      chk("to_res_err", 32'(p1_err), 32'd1);
      chk("to_ops_done", 32'(p1_ops), 32'd1);
      t = 0;
      while (!p1_cv && t < 20) begin
         tick();
         t++;
      end
      if (!p1_cv) bound_fail("to_next_dispatch");
      chk("to_next_op0", p1_cop0, 32'h40000000);
      for (int i = 0; i < 5; i++) tick();
      c1_cpl = 1'b1;
      c1_res = 32'h40C00000;
      t = 0;
      while (p1_cv && t < 20) begin
         tick();
         t++;
      end
      c1_cpl = 1'b0;
      chk("to_next_data", p1_rdata, 32'h40C00000);
      chk("to_next_err", 32'(p1_err), 32'd0);
      chk("to_next_ops", 32'(p1_ops), 32'd2);

      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
